// File: rtl/kernel_launch_pkg.sv
// Shared types and default widths for the kernel launch sequencer.
// Imported by sat_counter and kernel_launch_ctrl.
package kernel_launch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } launch_state_e;

  localparam int unsigned DEF_OUT_W          = 8;
  localparam int unsigned DEF_RUNS_W         = 8;
  localparam int unsigned DEF_CYCLE_W        = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
// Shared by the launch cycle counter and the per-invocation watchdog.
module sat_counter
  import kernel_launch_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kernel_launch_ctrl.sv
// Launch sequencer in front of a Dynamatic kernel wrapper: runs ap_start N times, returns one record.
// Optional per-invocation watchdog enabled by defining LAUNCH_TIMEOUT_EN.
module kernel_launch_ctrl
  import kernel_launch_pkg::*;
#(
  parameter int unsigned OUT_W          = DEF_OUT_W,
  parameter int unsigned RUNS_W         = DEF_RUNS_W,
  parameter int unsigned CYCLE_W        = DEF_CYCLE_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [RUNS_W-1:0]  cmd_runs,
  output logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic [OUT_W-1:0]   kern_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [OUT_W-1:0]   res_data,
  output logic [RUNS_W-1:0]  res_runs,
  output logic [CYCLE_W-1:0] res_cycles,
  output logic               res_timeout,
  output logic               busy
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("kernel_launch_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  launch_state_e     state, state_n;
  logic [RUNS_W-1:0] runs_q;
  logic [RUNS_W-1:0] done_q;
  logic [RUNS_W-1:0] done_inc;
  logic [OUT_W-1:0]  data_q;
  logic              accept;
  logic              run_done;
  logic              last_run;
  logic              counting;
  logic              wdog_trip;

  assign accept   = (state == IDLE) && cmd_valid;
  assign run_done = (state == RUN) && ap_done;
  assign done_inc = done_q + 1'b1;
  assign last_run = (done_inc == runs_q);
  assign counting = (state == START) || (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // NOTE: default assigned first so no path through the case can infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (cmd_valid) state_n = START;
      START: if (ap_ready)  state_n = RUN;
      RUN: begin
        if (ap_done) begin
          state_n = last_run ? RESP : START;
        end else if (wdog_trip) begin
          state_n = RESP;
        end
      end
      RESP:    if (res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The run target is latched once; a request for zero runs still launches the kernel once.
  always_ff @(posedge clk) begin
    if (rst) begin
      runs_q <= '0;
      done_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      runs_q <= (cmd_runs == '0) ? RUNS_W'(1) : cmd_runs;
      done_q <= '0;
      data_q <= '0;
    end else if (run_done) begin
      data_q <= kern_out;
      done_q <= done_inc;
    end
  end

  sat_counter #(
    .W (CYCLE_W)
  ) u_cycles (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (counting),
    .cnt (res_cycles)
  );

`ifdef LAUNCH_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] wdog;
  logic              timeout_q;

  // Cleared for the whole START phase so each invocation gets a fresh budget of RUN cycles.
  sat_counter #(
    .W (WDOG_W)
  ) u_wdog (
    .clk (clk),
    .rst (rst),
    .clr (state == START),
    .en  (state == RUN),
    .cnt (wdog)
  );

  assign wdog_trip = (state == RUN) && !ap_done && (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      timeout_q <= 1'b0;
    end else if (wdog_trip) begin
      timeout_q <= 1'b1;
    end
  end

  assign res_timeout = timeout_q;
`else
  assign wdog_trip   = 1'b0;
  assign res_timeout = 1'b0;
`endif

  // cmd_ready is held low during reset so nothing is launched while the block is being cleared.
  assign cmd_ready = (state == IDLE) && !rst;
  assign ap_start  = (state == START);
  assign res_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign res_data  = data_q;
  assign res_runs  = done_q;

endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// Self-checking bench for kernel_launch_ctrl: behavioural kernel plus a result scoreboard.
// The watchdog scenario is included when LAUNCH_TIMEOUT_EN is defined.
module tb_kernel_launch_ctrl;

  localparam int OUT_W   = 8;
  localparam int RUNS_W  = 8;
  localparam int CYCLE_W = 32;

  typedef struct packed {
    logic [OUT_W-1:0]   data;
    logic [RUNS_W-1:0]  runs;
    logic [CYCLE_W-1:0] cycles;
    logic               timeout;
  } res_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [RUNS_W-1:0]  cmd_runs = '0;
  logic               ap_start;
  logic               ap_ready;
  logic               ap_done = 1'b0;
  logic [OUT_W-1:0]   kern_out = '0;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic [OUT_W-1:0]   res_data;
  logic [RUNS_W-1:0]  res_runs;
  logic [CYCLE_W-1:0] res_cycles;
  logic               res_timeout;
  logic               busy;

  // Kernel model controls
  logic             k_idle    = 1'b1;
  logic             ready_en  = 1'b1;
  logic             no_done   = 1'b0;
  int               kern_n    = 10;
  logic [OUT_W-1:0] kout_base = '0;
  int               inv       = 0;

  // Scoreboard and per-cycle bookkeeping
  res_t sb[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  logic prev_done = 1'b0;
  logic chk_done  = 1'b1;
  logic got_res   = 1'b0;
  int   dn        = 0;
  int   cur_runs  = 1;
  int   start_cnt = 0;

  always #5 clk = ~clk;

  assign ap_ready = k_idle && ready_en;

  kernel_launch_ctrl #(
    .OUT_W          (OUT_W),
    .RUNS_W         (RUNS_W),
    .CYCLE_W        (CYCLE_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_runs    (cmd_runs),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .kern_out    (kern_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_runs    (res_runs),
    .res_cycles  (res_cycles),
    .res_timeout (res_timeout),
    .busy        (busy)
  );

  // Kernel: ap_done pulses N cycles after the start handshake cycle; busy (not ready) meanwhile.
  initial begin : kernel_model
    forever begin
      @(negedge clk);
      #1;
      if (cmd_valid && cmd_ready) inv = 0;
      if (!rst && ap_start && ap_ready) begin
        @(posedge clk);
        #1 k_idle = 1'b0;
        if (no_done) forever @(posedge clk);
        repeat (kern_n - 1) @(posedge clk);
        #1;
        ap_done  = 1'b1;
        kern_out = kout_base + OUT_W'(inv);
        inv++;
        @(posedge clk);
        #1;
        ap_done  = 1'b0;
        k_idle   = 1'b1;
        kern_out = '0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t mk_res(input logic [OUT_W-1:0] d, input int r, input int c, input logic t);
    res_t x;
    x.data    = d;
    x.runs    = RUNS_W'(r);
    x.cycles  = CYCLE_W'(c);
    x.timeout = t;
    return x;
  endfunction

  task automatic take_result();
    res_t e;
    if (sb.size() == 0) begin
      check("unexpected_result", res_valid, 1'b0);
      return;
    end
    e = sb.pop_front();
    check("res_data", res_data, e.data);
    check("res_runs", res_runs, e.runs);
    check("res_cycles", res_cycles, e.cycles);
    check("res_timeout", res_timeout, e.timeout);
    got_res = 1'b1;
  endtask

  // Advance to the next negedge and run the per-cycle observations.
  task automatic step();
    @(negedge clk);
    if (chk_done && prev_done) begin
      if (dn == cur_runs) check("res_valid_after_last_done", res_valid, 1'b1);
      else                check("ap_start_after_done", ap_start, 1'b1);
    end
    prev_done = ap_done;
    if (ap_done) dn++;
    if (ap_start) start_cnt++;
    if (res_valid && res_ready) take_result();
  endtask

  task automatic send_cmd(input int runs, input int n, input logic [OUT_W-1:0] base, input res_t exp);
    int w;
    kern_n    = n;
    kout_base = base;
    w = 0;
    while (!cmd_ready && w < 100) begin
      step();
      w++;
    end
    if (!cmd_ready) check("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_runs  = RUNS_W'(runs);
    dn        = 0;
    start_cnt = 0;
    cur_runs  = (runs == 0) ? 1 : runs;
    got_res   = 1'b0;
    sb.push_back(exp);
    step();
    cmd_valid = 1'b0;
    cmd_runs  = '0;
    check("ap_start_after_cmd", ap_start, 1'b1);
    check("cmd_ready_when_busy", cmd_ready, 1'b0);
  endtask

  task automatic wait_result(input int max_cycles);
    int w;
    w = 0;
    while (!got_res && w < max_cycles) begin
      step();
      w++;
    end
    if (!got_res) check("result_wait_expired", got_res, 1'b1);
    step();
    check("cmd_ready_after_resp", cmd_ready, 1'b1);
  endtask

  initial begin : main
    int w;
    // Reset state
    step();
    step();
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_ap_start", ap_start, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_res_data", res_data, 0);
    check("rst_res_runs", res_runs, 0);
    check("rst_res_cycles", res_cycles, 0);
    check("rst_res_timeout", res_timeout, 1'b0);
    rst = 1'b0;
    step();
    check("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Single invocation
    send_cmd(1, 10, 8'h5A, mk_res(8'h5A, 1, 11, 1'b0));
    wait_result(200);

    // Three back-to-back invocations
    send_cmd(3, 10, 8'h01, mk_res(8'h03, 3, 33, 1'b0));
    wait_result(200);

    // Zero runs behaves as one
    send_cmd(0, 10, 8'h33, mk_res(8'h33, 1, 11, 1'b0));
    wait_result(200);
    check("runs0_invocations", dn, 1);

    // Kernel not ready for the first 4 START cycles
    ready_en = 1'b0;
    send_cmd(1, 10, 8'h44, mk_res(8'h44, 1, 15, 1'b0));
    repeat (4) step();
    ready_en = 1'b1;
    wait_result(200);
    check("ap_start_cycles", start_cnt, 5);

    // Result back-pressure with a competing command
    res_ready = 1'b0;
    send_cmd(1, 10, 8'h77, mk_res(8'h77, 1, 11, 1'b0));
    w = 0;
    while (!res_valid && w < 100) begin
      step();
      w++;
    end
    check("stall_res_valid_seen", res_valid, 1'b1);
    cmd_valid = 1'b1;
    cmd_runs  = 8'd2;
    repeat (4) begin
      step();
      check("stall_res_valid", res_valid, 1'b1);
      check("stall_res_data", res_data, 8'h77);
      check("stall_res_runs", res_runs, 1);
      check("stall_res_cycles", res_cycles, 11);
      check("stall_cmd_ready", cmd_ready, 1'b0);
      check("stall_ap_start", ap_start, 1'b0);
    end
    cmd_valid = 1'b0;
    cmd_runs  = '0;
    res_ready = 1'b1;
    take_result();
    step();
    check("stall_release_cmd_ready", cmd_ready, 1'b1);
    check("stall_release_busy", busy, 1'b0);

    // Reset in the middle of RUN
    chk_done = 1'b0;
    send_cmd(1, 10, 8'h11, mk_res(8'h11, 1, 11, 1'b0));
    repeat (3) step();
    rst = 1'b1;
    step();
    check("midrst_ap_start", ap_start, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_res_valid", res_valid, 1'b0);
    check("midrst_res_cycles", res_cycles, 0);
    rst = 1'b0;
    step();
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    sb.delete();
    repeat (15) step();
    chk_done = 1'b1;

`ifdef LAUNCH_TIMEOUT_EN
    // Kernel never completes: watchdog closes the command
    no_done = 1'b1;
    send_cmd(1, 10, 8'h99, mk_res(8'h00, 0, 17, 1'b1));
    wait_result(200);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
